// File: rtl/channel_ccw_executor_if.sv
// Bundles the CCW request, channel-side, host-side and completion signals of
// channel_ccw_executor. The slave modport is the executor; the master modport is its environment.
interface channel_ccw_executor_if #(
    parameter int COUNT_WIDTH = 16
);
    logic [7:0]             ccw_addr;
    logic [7:0]             ccw_command;
    logic [COUNT_WIDTH-1:0] ccw_count;
    logic                   ccw_sli;
    logic                   ccw_valid;
    logic                   ccw_ready;

    logic [7:0]             chan_addr;
    logic [7:0]             chan_command;
    logic                   chan_start;
    logic                   chan_stop;
    logic                   chan_active;
    logic [1:0]             chan_condition_code;
    logic [7:0]             chan_status_tdata;
    logic                   chan_status_tvalid;
    logic [7:0]             chan_send_tdata;
    logic                   chan_send_tvalid;
    logic                   chan_send_tready;
    logic [7:0]             chan_recv_tdata;
    logic                   chan_recv_tvalid;
    logic                   chan_recv_tready;

    logic [7:0]             host_send_tdata;
    logic                   host_send_tvalid;
    logic                   host_send_tready;
    logic [7:0]             host_recv_tdata;
    logic                   host_recv_tvalid;
    logic                   host_recv_tready;

    logic                   done;
    logic [7:0]             done_status;
    logic [1:0]             done_cc;
    logic [COUNT_WIDTH-1:0] done_residual;
    logic                   done_length_error;

    modport slave (
        input  ccw_addr, ccw_command, ccw_count, ccw_sli, ccw_valid,
        output ccw_ready,
        output chan_addr, chan_command, chan_start, chan_stop,
        input  chan_active, chan_condition_code, chan_status_tdata, chan_status_tvalid,
        output chan_send_tdata, chan_send_tvalid,
        input  chan_send_tready,
        input  chan_recv_tdata, chan_recv_tvalid,
        output chan_recv_tready,
        input  host_send_tdata, host_send_tvalid,
        output host_send_tready,
        output host_recv_tdata, host_recv_tvalid,
        input  host_recv_tready,
        output done, done_status, done_cc, done_residual, done_length_error
    );

    modport master (
        output ccw_addr, ccw_command, ccw_count, ccw_sli, ccw_valid,
        input  ccw_ready,
        input  chan_addr, chan_command, chan_start, chan_stop,
        output chan_active, chan_condition_code, chan_status_tdata, chan_status_tvalid,
        input  chan_send_tdata, chan_send_tvalid,
        output chan_send_tready,
        output chan_recv_tdata, chan_recv_tvalid,
        input  chan_recv_tready,
        output host_send_tdata, host_send_tvalid,
        input  host_send_tready,
        input  host_recv_tdata, host_recv_tvalid,
        output host_recv_tready,
        input  done, done_status, done_cc, done_residual, done_length_error
    );
endinterface

// File: rtl/channel_ccw_executor.sv
// Runs one CCW at a time on the parallel channel: starts it, moves counted bytes
// between host and channel, stops overruns and reports a completion record.
module channel_ccw_executor #(
    parameter int COUNT_WIDTH    = 16,
    parameter int ACTIVE_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    channel_ccw_executor_if.slave bus
);
    localparam int TW = $clog2(ACTIVE_TIMEOUT + 1);

    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] START       = 3'd1;
    localparam logic [2:0] WAIT_ACTIVE = 3'd2;
    localparam logic [2:0] TRANSFER    = 3'd3;
    localparam logic [2:0] STOPPING    = 3'd4;
    localparam logic [2:0] DONE        = 3'd5;

    logic [2:0]             state_q, state_d;
    logic [7:0]             addr_q, addr_d;
    logic [7:0]             cmd_q, cmd_d;
    logic                   sli_q, sli_d;
    logic [COUNT_WIDTH-1:0] residual_q, residual_d;
    logic [7:0]             status_q, status_d;
    logic                   overrun_q, overrun_d;
    logic                   timeout_q, timeout_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic                   done_q, done_d;
    logic [7:0]             done_status_q, done_status_d;
    logic [1:0]             done_cc_q, done_cc_d;
    logic [COUNT_WIDTH-1:0] done_residual_q, done_residual_d;
    logic                   done_le_q, done_le_d;

    logic       ok, send_acc, recv_acc, chan_req;
    logic [1:0] cc_final;

    // Byte paths are combinational; they only open while bytes remain in TRANSFER.
    assign ok       = (state_q == TRANSFER) && (residual_q != '0);
    assign send_acc = bus.host_send_tvalid & bus.chan_send_tready & ok;
    assign recv_acc = bus.chan_recv_tvalid & bus.host_recv_tready & ok;
    assign chan_req = bus.chan_send_tready | bus.chan_recv_tvalid;
    assign cc_final = timeout_q ? 2'd3 : bus.chan_condition_code;

    assign bus.chan_send_tdata  = bus.host_send_tdata;
    assign bus.chan_send_tvalid = bus.host_send_tvalid & ok;
    assign bus.host_send_tready = bus.chan_send_tready & ok;
    assign bus.host_recv_tdata  = bus.chan_recv_tdata;
    assign bus.host_recv_tvalid = bus.chan_recv_tvalid & ok;
    assign bus.chan_recv_tready = bus.host_recv_tready & ok;

    assign bus.ccw_ready         = (state_q == IDLE);
    assign bus.chan_start        = (state_q == START);
    assign bus.chan_stop         = (state_q == STOPPING) && chan_req;
    assign bus.chan_addr         = addr_q;
    assign bus.chan_command      = cmd_q;
    assign bus.done              = done_q;
    assign bus.done_status       = done_status_q;
    assign bus.done_cc           = done_cc_q;
    assign bus.done_residual     = done_residual_q;
    assign bus.done_length_error = done_le_q;

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        cmd_d           = cmd_q;
        sli_d           = sli_q;
        residual_d      = residual_q;
        status_d        = status_q;
        overrun_d       = overrun_q;
        timeout_d       = timeout_q;
        timer_d         = timer_q;
        done_d          = 1'b0;
        done_status_d   = done_status_q;
        done_cc_d       = done_cc_q;
        done_residual_d = done_residual_q;
        done_le_d       = done_le_q;
        case (state_q)
            IDLE: begin
                if (bus.ccw_valid) begin
                    addr_d     = bus.ccw_addr;
                    cmd_d      = bus.ccw_command;
                    sli_d      = bus.ccw_sli;
                    residual_d = bus.ccw_count;
                    status_d   = 8'h00;
                    overrun_d  = 1'b0;
                    timeout_d  = 1'b0;
                    state_d    = START;
                end
            end
            START: begin
                timer_d = '0;
                state_d = WAIT_ACTIVE;
            end
            WAIT_ACTIVE: begin
                if (bus.chan_active) begin
                    state_d = TRANSFER;
                end else if (timer_q == TW'(ACTIVE_TIMEOUT)) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            TRANSFER: begin
                if (bus.chan_status_tvalid) status_d = bus.chan_status_tdata;
                if (send_acc | recv_acc) residual_d = residual_q - COUNT_WIDTH'(1);
                // Channel ending wins over a simultaneous overrun request.
                if (!bus.chan_active) begin
                    state_d = DONE;
                end else if (residual_q == '0 && chan_req) begin
                    overrun_d = 1'b1;
                    state_d   = STOPPING;
                end
            end
            STOPPING: begin
                if (bus.chan_status_tvalid) status_d = bus.chan_status_tdata;
                if (!bus.chan_active)  state_d = DONE;
                else if (!chan_req)    state_d = TRANSFER;
            end
            DONE: begin
                done_d          = 1'b1;
                done_status_d   = status_q;
                done_residual_d = residual_q;
                done_cc_d       = cc_final;
                done_le_d       = !sli_q && (overrun_q || residual_q != '0) && (cc_final != 2'd3);
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            cmd_q           <= '0;
            sli_q           <= 1'b0;
            residual_q      <= '0;
            status_q        <= '0;
            overrun_q       <= 1'b0;
            timeout_q       <= 1'b0;
            timer_q         <= '0;
            done_q          <= 1'b0;
            done_status_q   <= '0;
            done_cc_q       <= '0;
            done_residual_q <= '0;
            done_le_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            cmd_q           <= cmd_d;
            sli_q           <= sli_d;
            residual_q      <= residual_d;
            status_q        <= status_d;
            overrun_q       <= overrun_d;
            timeout_q       <= timeout_d;
            timer_q         <= timer_d;
            done_q          <= done_d;
            done_status_q   <= done_status_d;
            done_cc_q       <= done_cc_d;
            done_residual_q <= done_residual_d;
            done_le_q       <= done_le_d;
        end
    end
endmodule

// File: tb/tb_channel_ccw_executor.sv
// Bench for channel_ccw_executor: channel and host models run alongside each CCW,
// with a byte scoreboard and a captured completion record.
module tb_channel_ccw_executor;
    localparam int CW = 16;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    channel_ccw_executor_if #(.COUNT_WIDTH(CW)) bus();
    channel_ccw_executor #(.COUNT_WIDTH(CW), .ACTIVE_TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc_cnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int start_cyc = 0;
    int chan_sent = 0;
    int host_cnt = 0;
    bit stop_seen = 0;
    bit host_tready_seen = 0;
    logic [7:0]    d_status;
    logic [1:0]    d_cc;
    logic [CW-1:0] d_res;
    logic          d_le;
    logic [7:0]    wr_data [256];
    logic [7:0]    rd_data [256];
    logic [7:0]    exp_q [$];

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk) begin
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc_cnt;
            d_status = bus.done_status;
            d_cc     = bus.done_cc;
            d_res    = bus.done_residual;
            d_le     = bus.done_length_error;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic init_inputs();
        bus.ccw_addr = 0; bus.ccw_command = 0; bus.ccw_count = 0; bus.ccw_sli = 0; bus.ccw_valid = 0;
        bus.chan_active = 0; bus.chan_condition_code = 0; bus.chan_status_tdata = 0; bus.chan_status_tvalid = 0;
        bus.chan_send_tready = 0; bus.chan_recv_tdata = 0; bus.chan_recv_tvalid = 0;
        bus.host_send_tdata = 0; bus.host_send_tvalid = 0; bus.host_recv_tready = 0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 256; i++) begin
            wr_data[i] = 8'($urandom);
            rd_data[i] = 8'($urandom);
        end
    endtask

    task automatic issue_ccw(input logic [7:0] a, input logic [7:0] c, input logic [CW-1:0] n, input logic s);
        bit ok;
        ok = 0;
        @(posedge clk); #1;
        bus.ccw_addr = a; bus.ccw_command = c; bus.ccw_count = n; bus.ccw_sli = s; bus.ccw_valid = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.ccw_ready) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        bus.ccw_valid = 0;
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL ccw_accept: ccw_ready=%0b required 1", ok); end
    endtask

    task automatic chan_model(input bit is_wr, input int nbytes, input logic [7:0] st, input logic [1:0] cc,
                              input int act_delay, input logic [7:0] ea, input logic [7:0] ec);
        bit seen;
        int cyc;
        logic [7:0] e;
        seen = 0; cyc = 0; chan_sent = 0; stop_seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (bus.chan_start) begin seen = 1; start_cyc = cyc_cnt; end
        end
        checks++;
        if (seen !== 1'b1) begin errors++; $display("FAIL chan_start: seen=%0b required 1", seen); return; end
        checks++;
        if ({bus.chan_addr, bus.chan_command} !== {ea, ec})
            begin errors++; $display("FAIL chan_addr_cmd: got %h required %h", {bus.chan_addr, bus.chan_command}, {ea, ec}); end
        if (act_delay < 0) return;
        repeat (act_delay) @(posedge clk);
        @(posedge clk); #1;
        bus.chan_active = 1;
        while (chan_sent < nbytes && !stop_seen && cyc < 3000) begin
            @(posedge clk); #1;
            if (is_wr) bus.chan_send_tready = 1;
            else begin bus.chan_recv_tvalid = 1; bus.chan_recv_tdata = rd_data[chan_sent]; end
            @(negedge clk);
            if (bus.chan_stop) stop_seen = 1;
            if (is_wr && bus.chan_send_tvalid && bus.chan_send_tready) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL wr_byte: got %h required none", bus.chan_send_tdata); end
                else begin
                    e = exp_q.pop_front();
                    if (bus.chan_send_tdata !== e) begin errors++; $display("FAIL wr_byte: got %h required %h", bus.chan_send_tdata, e); end
                end
                chan_sent++;
            end
            if (!is_wr && bus.chan_recv_tvalid && bus.chan_recv_tready) chan_sent++;
            cyc++;
        end
        @(posedge clk); #1;
        bus.chan_send_tready = 0; bus.chan_recv_tvalid = 0;
        bus.chan_status_tdata = st; bus.chan_status_tvalid = 1;
        bus.chan_condition_code = cc; bus.chan_active = 0;
        @(posedge clk); #1;
        bus.chan_status_tvalid = 0;
    endtask

    task automatic host_source(input bit throttle, input int sc);
        int idx, cyc;
        idx = 0; cyc = 0;
        while (done_cnt == sc && cyc < 3000) begin
            @(posedge clk); #1;
            if (idx < 256) begin
                bus.host_send_tdata  = wr_data[idx];
                bus.host_send_tvalid = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
            end else bus.host_send_tvalid = 0;
            @(negedge clk);
            if (bus.host_send_tready) host_tready_seen = 1;
            if (bus.host_send_tvalid && bus.host_send_tready) idx++;
            cyc++;
        end
        bus.host_send_tvalid = 0;
        host_cnt = idx;
    endtask

    task automatic host_sink(input bit throttle, input int sc);
        int cyc;
        logic [7:0] e;
        cyc = 0;
        while (done_cnt == sc && cyc < 3000) begin
            @(posedge clk); #1;
            bus.host_recv_tready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (bus.host_recv_tvalid && bus.host_recv_tready) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL rd_byte: got %h required none", bus.host_recv_tdata); end
                else begin
                    e = exp_q.pop_front();
                    if (bus.host_recv_tdata !== e) begin errors++; $display("FAIL rd_byte: got %h required %h", bus.host_recv_tdata, e); end
                end
                host_cnt++;
            end
            cyc++;
        end
        bus.host_recv_tready = 0;
    endtask

    task automatic run_ccw(input bit is_wr, input int count, input logic sli, input int nbytes,
                           input logic [7:0] st, input logic [1:0] cc, input bit throttle);
        int sc, k;
        logic [7:0] a, c;
        sc = done_cnt;
        exp_q.delete();
        host_cnt = 0; host_tready_seen = 0;
        a = 8'($urandom_range(1, 255));
        c = is_wr ? 8'h01 : 8'h02;
        k = (count < nbytes) ? count : nbytes;
        for (int i = 0; i < k; i++) exp_q.push_back(is_wr ? wr_data[i] : rd_data[i]);
        fork
            issue_ccw(a, c, CW'(count), sli);
            chan_model(is_wr, nbytes, st, cc, 1, a, c);
            begin
                if (is_wr) host_source(throttle, sc);
                else       host_sink(throttle, sc);
            end
        join
        for (int i = 0; i < 20 && done_cnt == sc; i++) @(negedge clk);
        checks++;
        if (done_cnt !== sc + 1) begin errors++; $display("FAIL done_count: got %0d required %0d", done_cnt - sc, 1); end
        checks++;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL bytes_left: got %0d required 0", exp_q.size()); end
    endtask

    task automatic test_reset();
        init_inputs();
        reset_n = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.ccw_ready, bus.chan_start, bus.chan_stop, bus.done, bus.done_length_error} !== 5'b10000)
            begin errors++; $display("FAIL reset_ctrl: got %b required 10000", {bus.ccw_ready, bus.chan_start, bus.chan_stop, bus.done, bus.done_length_error}); end
        checks++;
        if ({bus.chan_addr, bus.chan_command, bus.done_status, bus.done_residual, bus.done_cc} !== '0)
            begin errors++; $display("FAIL reset_data: got %h required 0", {bus.chan_addr, bus.chan_command, bus.done_status, bus.done_residual, bus.done_cc}); end
        reset_n = 1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write_basic();
        fill_random();
        wr_data[0] = 8'hAA; wr_data[1] = 8'hBB; wr_data[2] = 8'hCC;
        run_ccw(1, 3, 0, 3, 8'h0C, 2'd0, 0);
        checks++; if (chan_sent !== 3) begin errors++; $display("FAIL wb_sent: got %0d required 3", chan_sent); end
        checks++; if (d_res !== 0) begin errors++; $display("FAIL wb_residual: got %0d required 0", d_res); end
        checks++; if (d_status !== 8'h0C) begin errors++; $display("FAIL wb_status: got %h required 0c", d_status); end
        checks++; if (d_le !== 1'b0) begin errors++; $display("FAIL wb_len_err: got %b required 0", d_le); end
        checks++; if (d_cc !== 2'd0) begin errors++; $display("FAIL wb_cc: got %0d required 0", d_cc); end
        checks++; if (stop_seen !== 1'b0) begin errors++; $display("FAIL wb_stop: got %b required 0", stop_seen); end
    endtask

    task automatic test_read_overrun(input logic sli);
        fill_random();
        run_ccw(0, 2, sli, 4, 8'h0C, 2'd0, 0);
        checks++; if (host_cnt !== 2) begin errors++; $display("FAIL ro_delivered: got %0d required 2", host_cnt); end
        checks++; if (stop_seen !== 1'b1 || chan_sent !== 2) begin errors++; $display("FAIL ro_stop: stop=%b after %0d bytes required stop=1 after 2", stop_seen, chan_sent); end
        checks++; if (d_res !== 0) begin errors++; $display("FAIL ro_residual: got %0d required 0", d_res); end
        checks++; if (d_le !== !sli) begin errors++; $display("FAIL ro_len_err sli=%b: got %b required %b", sli, d_le, !sli); end
    endtask

    task automatic test_read_early_end();
        fill_random();
        run_ccw(0, 5, 0, 2, 8'h0E, 2'd0, 0);
        checks++; if (host_cnt !== 2) begin errors++; $display("FAIL ee_delivered: got %0d required 2", host_cnt); end
        checks++; if (d_res !== 3) begin errors++; $display("FAIL ee_residual: got %0d required 3", d_res); end
        checks++; if (d_le !== 1'b1) begin errors++; $display("FAIL ee_len_err: got %b required 1", d_le); end
        checks++; if (d_status !== 8'h0E) begin errors++; $display("FAIL ee_status: got %h required 0e", d_status); end
    endtask

    task automatic test_write_count_zero();
        fill_random();
        run_ccw(1, 0, 0, 1, 8'h0C, 2'd0, 0);
        checks++; if (stop_seen !== 1'b1 || chan_sent !== 0) begin errors++; $display("FAIL cz_stop: stop=%b sent=%0d required stop=1 sent=0", stop_seen, chan_sent); end
        checks++; if (host_tready_seen !== 1'b0) begin errors++; $display("FAIL cz_tready: got %b required 0", host_tready_seen); end
        checks++; if (d_le !== 1'b1) begin errors++; $display("FAIL cz_len_err: got %b required 1", d_le); end
        checks++; if (d_res !== 0) begin errors++; $display("FAIL cz_residual: got %0d required 0", d_res); end
    endtask

    task automatic test_timeout();
        int sc, dly;
        sc = done_cnt;
        fork
            issue_ccw(8'h21, 8'h01, CW'(7), 0);
            chan_model(1, 0, 8'h00, 2'd0, -1, 8'h21, 8'h01);
        join
        for (int i = 0; i < 100 && done_cnt == sc; i++) @(negedge clk);
        checks++;
        if (done_cnt !== sc + 1) begin errors++; $display("FAIL to_done: got %0d required 1", done_cnt - sc); end
        dly = done_cyc - start_cyc;
        checks++;
        if (dly < TO + 1 || dly > TO + 4) begin errors++; $display("FAIL to_delay: got %0d required %0d..%0d", dly, TO + 1, TO + 4); end
        checks++; if (d_cc !== 2'd3) begin errors++; $display("FAIL to_cc: got %0d required 3", d_cc); end
        checks++; if (d_le !== 1'b0) begin errors++; $display("FAIL to_len_err: got %b required 0", d_le); end
        checks++; if (d_res !== 7) begin errors++; $display("FAIL to_residual: got %0d required 7", d_res); end
    endtask

    task automatic test_short_busy_cc3();
        fill_random();
        run_ccw(1, 4, 0, 0, 8'h10, 2'd3, 0);
        checks++; if (d_cc !== 2'd3) begin errors++; $display("FAIL sb_cc: got %0d required 3", d_cc); end
        checks++; if (d_res !== 4) begin errors++; $display("FAIL sb_residual: got %0d required 4", d_res); end
        checks++; if (d_le !== 1'b0) begin errors++; $display("FAIL sb_len_err: got %b required 0", d_le); end
        checks++; if (d_status !== 8'h10) begin errors++; $display("FAIL sb_status: got %h required 10", d_status); end
    endtask

    task automatic test_reset_mid();
        int sc;
        bit seen;
        sc = done_cnt; seen = 0;
        fill_random();
        issue_ccw(8'h33, 8'h02, CW'(10), 0);
        for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = bus.chan_start; end
        @(posedge clk); #1;
        bus.chan_active = 1; bus.host_recv_tready = 1;
        bus.chan_recv_tvalid = 1; bus.chan_recv_tdata = rd_data[0];
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset_n = 0;
        #1;
        checks++;
        if ({bus.ccw_ready, bus.chan_start, bus.chan_stop, bus.done, bus.done_length_error, bus.host_recv_tvalid} !== 6'b100000)
            begin errors++; $display("FAIL rm_ctrl: got %b required 100000", {bus.ccw_ready, bus.chan_start, bus.chan_stop, bus.done, bus.done_length_error, bus.host_recv_tvalid}); end
        checks++;
        if ({bus.chan_addr, bus.chan_command, bus.done_status, bus.done_residual, bus.done_cc} !== '0)
            begin errors++; $display("FAIL rm_data: got %h required 0", {bus.chan_addr, bus.chan_command, bus.done_status, bus.done_residual, bus.done_cc}); end
        init_inputs();
        repeat (2) @(negedge clk);
        reset_n = 1;
        repeat (4) @(negedge clk);
        checks++;
        if (done_cnt !== sc) begin errors++; $display("FAIL rm_no_done: got %0d required 0", done_cnt - sc); end
    endtask

    task automatic test_stream_throttle();
        fill_random();
        run_ccw(1, 64, 0, 64, 8'h0C, 2'd1, 1);
        checks++; if (chan_sent !== 64) begin errors++; $display("FAIL st_wr_count: got %0d required 64", chan_sent); end
        checks++; if (d_res !== 0 || d_le !== 1'b0) begin errors++; $display("FAIL st_wr_done: res=%0d le=%b required 0/0", d_res, d_le); end
        checks++; if (d_cc !== 2'd1) begin errors++; $display("FAIL st_wr_cc: got %0d required 1", d_cc); end
        fill_random();
        run_ccw(0, 64, 0, 64, 8'h0C, 2'd0, 1);
        checks++; if (host_cnt !== 64) begin errors++; $display("FAIL st_rd_count: got %0d required 64", host_cnt); end
        checks++; if (d_res !== 0 || d_le !== 1'b0) begin errors++; $display("FAIL st_rd_done: res=%0d le=%b required 0/0", d_res, d_le); end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_overrun(1'b0);
        test_read_overrun(1'b1);
        test_read_early_end();
        test_write_count_zero();
        test_timeout();
        test_short_busy_cc3();
        test_reset_mid();
        test_stream_throttle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
